// File: rtl/awg_i2c_pkg.sv
// ============================================================================
// Module   : awg_i2c_pkg
// Brief    : Shared types and constants for the AWG I2C DAC output path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package awg_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_e;

  localparam logic [1:0] c_fm_cmd       = 2'b00;
  localparam logic [6:0] c_def_dev_addr = 7'h62;

  // Framing flags travelling alongside each byte to the transmitter.
  typedef struct packed {
    logic start;
    logic stop;
  } byte_flags_t;

  localparam byte_flags_t c_flags_none = '{start: 1'b0, stop: 1'b0};

  function automatic logic [7:0] hi_byte(input logic [1:0] pd, input logic [11:0] code);
    return {c_fm_cmd, pd, code[11:8]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module   : sample_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             w_wr;
  logic             w_rd;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign w_wr = wr_en_i && !full_o;
  assign w_rd = rd_en_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; the level and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/dac_sample_framer.sv
// ============================================================================
// Module   : dac_sample_framer
// Brief    : Buffers 12-bit DAC samples and frames them as I2C write bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_sample_framer
  import awg_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = c_def_dev_addr,
  parameter logic [1:0] PD_BITS    = 2'b00,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [11:0]                   s_sample,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_byte,
  output logic                          m_start,
  output logic                          m_stop,
  input  logic                          nack,
  input  logic                          nack_clr,
  output logic                          busy,
  output logic                          err_nack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int              BW           = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]   c_burst_last = BW'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [11:0]        cur_q, cur_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               stop_q, stop_d;
  logic               err_q, err_d;
  logic               m_valid_q, m_valid_d;
  logic [7:0]         m_byte_q, m_byte_d;
  byte_flags_t        flags_q, flags_d;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_hs;
  logic [11:0]        w_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  assign s_ready    = !w_full && !rst;
  assign w_push     = s_valid && s_ready;
  assign w_hs       = m_valid_q && m_ready;

  assign m_valid    = m_valid_q;
  assign m_byte     = m_byte_q;
  assign m_start    = flags_q.start;
  assign m_stop     = flags_q.stop;
  assign busy       = (state_q != ST_IDLE);
  assign err_nack   = err_q;
  assign fifo_level = w_level;

  sample_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_push),
    .wr_data_i (s_sample),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (w_level)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    burst_d   = burst_q;
    stop_d    = stop_q;
    err_d     = err_q;
    w_pop     = 1'b0;
    m_valid_d = 1'b0;
    m_byte_d  = '0;
    flags_d   = c_flags_none;

    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          cur_d   = w_head;
          burst_d = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_hs) state_d = ST_HI;
      end
      ST_HI: begin
        // Stop decision uses the level before any same-cycle push.
        if (w_hs) begin
          stop_d  = (w_level == '0) || (burst_q == c_burst_last);
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (w_hs) begin
          if (stop_q) begin
            state_d = ST_IDLE;
          end else begin
            w_pop   = 1'b1;
            cur_d   = w_head;
            burst_d = burst_q + BW'(1);
            state_d = ST_HI;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A NACK overrides any coincident handshake and abandons the current sample.
    if (nack) begin
      err_d = 1'b1;
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        w_pop   = 1'b0;
        cur_d   = cur_q;
        burst_d = burst_q;
        stop_d  = stop_q;
      end
    end else if (nack_clr) begin
      err_d = 1'b0;
    end

    case (state_d)
      ST_ADDR: begin
        m_valid_d     = 1'b1;
        m_byte_d      = {DEV_ADDR, 1'b0};
        flags_d.start = 1'b1;
      end
      ST_HI: begin
        m_valid_d = 1'b1;
        m_byte_d  = hi_byte(PD_BITS, cur_d);
      end
      ST_LO: begin
        m_valid_d    = 1'b1;
        m_byte_d     = cur_d[7:0];
        flags_d.stop = stop_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      burst_q   <= '0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_byte_q  <= '0;
      flags_q   <= c_flags_none;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      burst_q   <= burst_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_byte_q  <= m_byte_d;
      flags_q   <= flags_d;
    end
  end

endmodule

`default_nettype wire
